ysyx_22040237_lsu: RTL and testbench
====================================

# ysyx_22040237_lsu

Load/store stage of the ysyx_22040237 core. It sits directly downstream of the execute unit and consumes the ALU result, the 7-bit load/store info bus and the store data. It issues 64-bit-aligned memory requests over a valid/ready bus with byte-lane masking. It returns a writeback packet with load data extended to XLEN; non-memory instructions pass through with one cycle of latency.

## Interface
Parameters:
- XLEN, 64, data/address width; only 64 is supported.
- TIMEOUT_CYC, 255, maximum cycles spent in REQ+RSP before a bus error is declared; 0 disables the timeout.

Ports:
- clk  in  1  clock.
- rst  in  1  reset; **synchronous, active-high, single clock domain.**
- in_valid_i  in  1  execute result valid.
- in_ready_o  out  1  stage can accept an instruction; high only in IDLE.
- rd_wr_en_i  in  1  destination write enable.
- rd_idx_i  in  5  destination register index.
- alu_res_i  in  64  ALU result; this is the effective address for load/store.
- ls_info_bus_i  in  7  {dw, word, db, byte, usign, store, load}, bit 0 = load.
- rs2_store_i  in  64  store data.
- mem_req_valid_o  out  1  memory request valid.
- mem_req_ready_i  in  1  memory accepts request.
- mem_req_we_o  out  1  1 = write.
- mem_req_addr_o  out  64  {alu_res[63:3], 3'b0}.
- mem_req_wdata_o  out  64  lane-shifted store data.
- mem_req_wmask_o  out  8  byte-lane mask.
- mem_rsp_valid_i  in  1  read data / write acknowledge.
- mem_rsp_rdata_i  in  64  read data.
- wb_valid_o  out  1  writeback packet valid; lasts exactly one cycle.
- wb_rd_wr_en_o  out  1  register write enable.
- wb_rd_idx_o  out  5  register index.
- wb_data_o  out  64  writeback data.
- bus_err_o  out  1  timeout flag; qualified by wb_valid_o.
- misalign_o  out  1  misaligned-access flag; qualified by wb_valid_o.

## Operation
- FSM states: IDLE, REQ, RSP, WB.
- **IDLE**
  - Accepts when in_valid_i is high.
  - Non-memory op (load=store=0): latch rd/data, go to WB.
  - Memory op: latch all inputs, go to REQ.
  - Store has priority if load and store are both set.
- **REQ**
  - mem_req_valid_o=1, with addr/we/wdata/wmask held stable until mem_req_ready_i.
  - On handshake, go to RSP.
- **RSP**
  - Waits for mem_rsp_valid_i, then goes to WB.
  - Load: wb_data = extend(rdata >> 8*off).
  - Store: wb_rd_wr_en_o=0, wb_data=0.
  - mem_rsp_valid_i is ignored in every other state.
- **WB**
  - wb_valid_o=1 for one cycle, then IDLE.
- **Size decode:** priority dw > word > db > byte; no size bit set means byte. Sizes are 8/4/2/1 bytes.
- **Byte lanes:** off = alu_res[2:0].
  - wmask = (size-ones) << off, truncated to 8 bits.
  - wdata = rs2 << 8*off.
  - Load extension: sign-extend from bit 8*size-1 unless usign; usign zero-extends. dw is not extended.
- **Timeout:** counter cleared on accept, incremented each cycle in REQ/RSP. On reaching TIMEOUT_CYC:
  - REQ drops mem_req_valid_o, and the FSM goes to WB with bus_err_o=1, wb_rd_wr_en_o=0, wb_data=0.
  - After a bus error the core halts; no further response is expected.
- **Reset:** rst in any state goes to IDLE the next cycle. An un-handshaken request is abandoned.

## Timing
- All outputs register from state and latched data. Reset values: in_ready_o=1; every other output 0.
- Non-memory op: accepted at cycle N, wb_valid_o at N+1; next accept at N+2.
- Load/store with ready=1 and a response one cycle later:
  - accept at N
  - REQ handshake at N+1
  - rsp at N+2
  - wb_valid_o at N+3
- Throughput is at most one instruction per two cycles. No buffering beyond one instruction.
- Back-pressure: mem_req_ready_i low holds REQ indefinitely, up to the timeout.

## Configuration
- YSYX_22040237_LSU_MISALIGN_EN:
  - **Defined:** a memory op with off % size != 0 skips REQ/RSP. It goes IDLE→WB with misalign_o=1, wb_rd_wr_en_o=0, wb_data=alu_res (the faulting address). No memory request is issued.
  - **Undefined:** misalign_o is tied 0. Misaligned accesses are issued with the truncated mask; lanes past byte 7 are dropped.

## Test plan
- **ALU pass-through:** in rd=5, alu_res=0x1234, ls_info=0 → next cycle wb_valid=1, rd=5, data=0x1234, wr_en=1.
- **Load signed byte:** lb at addr 0x8000_0003, rdata=0x0000_0000_8000_0000 → mask unused, wb_data=0xFFFF_FFFF_FFFF_FF80. The same access with lbu → 0x80.
- **Store half:** sh at addr 0x8000_0006, rs2=0xABCD → addr 0x8000_0000, wmask=0xC0, wdata=0xABCD_0000_0000_0000. After the ack, wb_rd_wr_en=0.
- **Back-pressure and timeout:** TIMEOUT_CYC=4, ready held 0 → mem_req_valid stays asserted, then WB with bus_err_o=1 four cycles after accept, wr_en=0.
- **Misaligned:** lw at 0x8000_0002 with the macro defined → no request, misalign_o=1, wb_data=0x8000_0002. With the macro undefined → request with wmask irrelevant, data = rdata>>16 sign-extended from bit 31.
- **Reset in RSP:** rst asserted while waiting for rsp → next cycle IDLE, in_ready_o=1, mem_req_valid_o=0, wb_valid_o=0. A later rsp is ignored.

Source files
------------

// File: rtl/ysyx_22040237_lsu.sv
// ysyx_22040237_lsu -- load/store stage of the ysyx_22040237 core.
//
// Takes one instruction at a time from execute, issues a single 64-bit
// aligned memory access over a valid/ready bus with byte-lane masking, and
// returns a one-cycle writeback packet. Non-memory instructions pass
// straight through to writeback with one cycle of latency.
//
// Optional feature: define YSYX_22040237_LSU_MISALIGN_EN to trap accesses
// whose lane offset is not a multiple of the access size. They go to
// writeback with misalign_o set and never reach the bus. Without the macro,
// misalign_o is tied low and misaligned accesses are issued with a truncated
// lane mask.
module ysyx_22040237_lsu #(
  parameter int XLEN        = 64,  // only 64 is supported
  parameter int TIMEOUT_CYC = 255  // 0 disables the bus timeout
) (
  input  logic            clk,
  input  logic            rst,
  // execute side
  input  logic            in_valid_i,
  output logic            in_ready_o,
  input  logic            rd_wr_en_i,
  input  logic [4:0]      rd_idx_i,
  input  logic [XLEN-1:0] alu_res_i,
  input  logic [6:0]      ls_info_bus_i,
  input  logic [XLEN-1:0] rs2_store_i,
  // memory request channel
  output logic            mem_req_valid_o,
  input  logic            mem_req_ready_i,
  output logic            mem_req_we_o,
  output logic [XLEN-1:0] mem_req_addr_o,
  output logic [XLEN-1:0] mem_req_wdata_o,
  output logic [7:0]      mem_req_wmask_o,
  // memory response channel
  input  logic            mem_rsp_valid_i,
  input  logic [XLEN-1:0] mem_rsp_rdata_i,
  // writeback
  output logic            wb_valid_o,
  output logic            wb_rd_wr_en_o,
  output logic [4:0]      wb_rd_idx_o,
  output logic [XLEN-1:0] wb_data_o,
  output logic            bus_err_o,
  output logic            misalign_o
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_RSP  = 2'd2,
    S_WB   = 2'd3
  } state_t;

  // ls_info_bus_i = {dw, word, db, byte, usign, store, load}
  localparam int INFO_LOAD  = 0;
  localparam int INFO_STORE = 1;
  localparam int INFO_USIGN = 2;
  localparam int INFO_BYTE  = 3;
  localparam int INFO_DB    = 4;
  localparam int INFO_WORD  = 5;
  localparam int INFO_DW    = 6;

  // Access size is kept as log2(bytes): 0=1B, 1=2B, 2=4B, 3=8B.
  function automatic logic [7:0] lane_mask(input logic [1:0] size,
                                           input logic [2:0] off);
    logic [7:0] ones;
    case (size)
      2'd0:    ones = 8'h01;
      2'd1:    ones = 8'h03;
      2'd2:    ones = 8'h0F;
      default: ones = 8'hFF;
    endcase
    // Lanes shifted past byte 7 fall off the 8-bit result.
    return ones << off;
  endfunction

  // Bring the addressed lanes down to bit 0 and extend to XLEN.
  function automatic logic [XLEN-1:0] load_extend(input logic [XLEN-1:0] rdata,
                                                  input logic [2:0]      off,
                                                  input logic [1:0]      size,
                                                  input logic            usign);
    logic [XLEN-1:0] s;
    s = rdata >> {off, 3'b000};
    case (size)
      2'd0:    return usign ? {{(XLEN-8){1'b0}},  s[7:0]}
                            : {{(XLEN-8){s[7]}},  s[7:0]};
      2'd1:    return usign ? {{(XLEN-16){1'b0}}, s[15:0]}
                            : {{(XLEN-16){s[15]}}, s[15:0]};
      2'd2:    return usign ? {{(XLEN-32){1'b0}}, s[31:0]}
                            : {{(XLEN-32){s[31]}}, s[31:0]};
      default: return s;  // doubleword fills the register, nothing to extend
    endcase
  endfunction

`ifdef YSYX_22040237_LSU_MISALIGN_EN
  // True when the lane offset is not a multiple of the access size.
  function automatic logic is_misaligned(input logic [1:0] size,
                                         input logic [2:0] off);
    logic [2:0] low;
    case (size)
      2'd0:    low = 3'b000;
      2'd1:    low = 3'b001;
      2'd2:    low = 3'b011;
      default: low = 3'b111;
    endcase
    return (off & low) != 3'b000;
  endfunction
`endif

  // ---------------------------------------------------------------------
  // Incoming instruction decode
  // ---------------------------------------------------------------------
  logic       is_store_in;
  logic       is_mem_in;
  logic [2:0] off_in;
  logic [1:0] size_in;
  logic       mis_in;

  // Store wins when both load and store are flagged.
  assign is_store_in = ls_info_bus_i[INFO_STORE];
  assign is_mem_in   = ls_info_bus_i[INFO_LOAD] | ls_info_bus_i[INFO_STORE];
  assign off_in      = alu_res_i[2:0];

  // Size decode with priority dw > word > db > byte; no size bit means byte.
  // NOTE: every variable driven in an always_comb gets a default first, so no path can infer a latch.
  always_comb begin
    size_in = 2'd0;
    if (ls_info_bus_i[INFO_DW])        size_in = 2'd3;
    else if (ls_info_bus_i[INFO_WORD]) size_in = 2'd2;
    else if (ls_info_bus_i[INFO_DB])   size_in = 2'd1;
    else if (ls_info_bus_i[INFO_BYTE]) size_in = 2'd0;
  end

`ifdef YSYX_22040237_LSU_MISALIGN_EN
  assign mis_in = is_mem_in & is_misaligned(size_in, off_in);
`else
  assign mis_in = 1'b0;
`endif

  // ---------------------------------------------------------------------
  // State and latched instruction
  // ---------------------------------------------------------------------
  state_t          state_q, state_d;
  logic            we_q;
  logic            usign_q;
  logic [1:0]      size_q;
  logic            rd_wr_en_q;
  logic [4:0]      rd_idx_q;
  logic [XLEN-1:0] addr_q;
  logic [XLEN-1:0] wdata_q;
  logic [7:0]      wmask_q;
  logic [31:0]     cnt_q;
  logic            wb_wr_en_q;
  logic [XLEN-1:0] wb_data_q;
  logic            bus_err_q;
`ifdef YSYX_22040237_LSU_MISALIGN_EN
  logic            misalign_q;
`endif

  // The counter reads 0 in the first REQ cycle, so checking cnt+2 lands
  // writeback exactly TIMEOUT_CYC cycles after the accept (two at minimum).
  logic tmo_hit;
  assign tmo_hit = (TIMEOUT_CYC != 0) && ((cnt_q + 32'd2) >= 32'(TIMEOUT_CYC));

  logic accept;
  logic rsp_fire;
  logic tmo_fire;

  // Next-state decode plus the one-cycle strobes the datapath acts on.
  always_comb begin
    state_d  = state_q;
    accept   = 1'b0;
    rsp_fire = 1'b0;
    tmo_fire = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (in_valid_i) begin
          accept  = 1'b1;
          state_d = (!is_mem_in || mis_in) ? S_WB : S_REQ;
        end
      end
      S_REQ: begin
        // A handshake in the same cycle as the timeout still counts.
        if (mem_req_ready_i) begin
          state_d = S_RSP;
        end else if (tmo_hit) begin
          tmo_fire = 1'b1;
          state_d  = S_WB;
        end
      end
      S_RSP: begin
        if (mem_rsp_valid_i) begin
          rsp_fire = 1'b1;
          state_d  = S_WB;
        end else if (tmo_hit) begin
          tmo_fire = 1'b1;
          state_d  = S_WB;
        end
      end
      S_WB:    state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // State register; reset abandons any outstanding request.
  // NOTE: sequential state is written with non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Instruction latch, timeout counter and writeback packet construction.
  // NOTE: datapath registers are reset too, because every output must read 0 straight out of reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      we_q       <= 1'b0;
      usign_q    <= 1'b0;
      size_q     <= 2'd0;
      rd_wr_en_q <= 1'b0;
      rd_idx_q   <= 5'd0;
      addr_q     <= '0;
      wdata_q    <= '0;
      wmask_q    <= 8'h00;
      cnt_q      <= 32'd0;
      wb_wr_en_q <= 1'b0;
      wb_data_q  <= '0;
      bus_err_q  <= 1'b0;
`ifdef YSYX_22040237_LSU_MISALIGN_EN
      misalign_q <= 1'b0;
`endif
    end else begin
      if (state_q == S_REQ || state_q == S_RSP) begin
        cnt_q <= cnt_q + 32'd1;
      end

      if (accept) begin
        cnt_q      <= 32'd0;
        we_q       <= is_store_in;
        usign_q    <= ls_info_bus_i[INFO_USIGN];
        size_q     <= size_in;
        rd_wr_en_q <= rd_wr_en_i;
        rd_idx_q   <= rd_idx_i;
        addr_q     <= alu_res_i;
        wdata_q    <= rs2_store_i << {off_in, 3'b000};
        wmask_q    <= lane_mask(size_in, off_in);
        bus_err_q  <= 1'b0;
`ifdef YSYX_22040237_LSU_MISALIGN_EN
        misalign_q <= mis_in;
`endif
        // Pass-through writes the ALU result; a misalign trap reports the
        // faulting address; real memory ops fill this in at the response.
        wb_wr_en_q <= is_mem_in ? 1'b0 : rd_wr_en_i;
        wb_data_q  <= (is_mem_in && !mis_in) ? '0 : alu_res_i;
      end

      // Stores keep the zero packet set up at accept.
      if (rsp_fire && !we_q) begin
        wb_wr_en_q <= rd_wr_en_q;
        wb_data_q  <= load_extend(mem_rsp_rdata_i, addr_q[2:0], size_q, usign_q);
      end

      if (tmo_fire) begin
        bus_err_q  <= 1'b1;
        wb_wr_en_q <= 1'b0;
        wb_data_q  <= '0;
      end
    end
  end

  // ---------------------------------------------------------------------
  // Outputs: decoded from state and latched data only
  // ---------------------------------------------------------------------
  assign in_ready_o      = (state_q == S_IDLE);
  assign mem_req_valid_o = (state_q == S_REQ);
  assign mem_req_we_o    = we_q;
  assign mem_req_addr_o  = {addr_q[XLEN-1:3], 3'b000};
  assign mem_req_wdata_o = wdata_q;
  assign mem_req_wmask_o = wmask_q;
  assign wb_valid_o      = (state_q == S_WB);
  assign wb_rd_wr_en_o   = wb_wr_en_q;
  assign wb_rd_idx_o     = rd_idx_q;
  assign wb_data_o       = wb_data_q;
  assign bus_err_o       = bus_err_q;
`ifdef YSYX_22040237_LSU_MISALIGN_EN
  assign misalign_o      = misalign_q;
`else
  assign misalign_o      = 1'b0;
`endif

endmodule

// File: tb/tb_ysyx_22040237_lsu.sv
// tb_ysyx_22040237_lsu -- scoreboard bench for the load/store stage.
// Expected writeback packets are queued when an instruction is driven and
// compared when wb_valid_o appears. Expected bus fields and load data come
// from a byte-by-byte reference model.
module tb_ysyx_22040237_lsu;

  localparam int TMO = 4;

`ifdef YSYX_22040237_LSU_MISALIGN_EN
  localparam bit MIS_EN = 1'b1;
`else
  localparam bit MIS_EN = 1'b0;
`endif

  logic        clk;
  logic        rst;
  logic        in_valid_i;
  logic        in_ready_o;
  logic        rd_wr_en_i;
  logic [4:0]  rd_idx_i;
  logic [63:0] alu_res_i;
  logic [6:0]  ls_info_bus_i;
  logic [63:0] rs2_store_i;
  logic        mem_req_valid_o;
  logic        mem_req_ready_i;
  logic        mem_req_we_o;
  logic [63:0] mem_req_addr_o;
  logic [63:0] mem_req_wdata_o;
  logic [7:0]  mem_req_wmask_o;
  logic        mem_rsp_valid_i;
  logic [63:0] mem_rsp_rdata_i;
  logic        wb_valid_o;
  logic        wb_rd_wr_en_o;
  logic [4:0]  wb_rd_idx_o;
  logic [63:0] wb_data_o;
  logic        bus_err_o;
  logic        misalign_o;

  ysyx_22040237_lsu #(.XLEN(64), .TIMEOUT_CYC(TMO)) dut (
    .clk             (clk),
    .rst             (rst),
    .in_valid_i      (in_valid_i),
    .in_ready_o      (in_ready_o),
    .rd_wr_en_i      (rd_wr_en_i),
    .rd_idx_i        (rd_idx_i),
    .alu_res_i       (alu_res_i),
    .ls_info_bus_i   (ls_info_bus_i),
    .rs2_store_i     (rs2_store_i),
    .mem_req_valid_o (mem_req_valid_o),
    .mem_req_ready_i (mem_req_ready_i),
    .mem_req_we_o    (mem_req_we_o),
    .mem_req_addr_o  (mem_req_addr_o),
    .mem_req_wdata_o (mem_req_wdata_o),
    .mem_req_wmask_o (mem_req_wmask_o),
    .mem_rsp_valid_i (mem_rsp_valid_i),
    .mem_rsp_rdata_i (mem_rsp_rdata_i),
    .wb_valid_o      (wb_valid_o),
    .wb_rd_wr_en_o   (wb_rd_wr_en_o),
    .wb_rd_idx_o     (wb_rd_idx_o),
    .wb_data_o       (wb_data_o),
    .bus_err_o       (bus_err_o),
    .misalign_o      (misalign_o)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  typedef struct {
    logic [63:0] addr;
    logic [6:0]  info;
    logic [63:0] rs2;
    logic [4:0]  rd;
    logic        we;
    logic [63:0] rdata;
    int          rdy_dly;   // -1: never raise ready
    logic        force_exp; // use exp_data instead of the model
    logic [63:0] exp_data;
  } op_t;

  typedef struct {
    logic        wr_en;
    logic [4:0]  idx;
    logic [63:0] data;
    logic        err;
    logic        mis;
    int          cyc0;
    int          lat;       // 0: latency not checked
  } exp_t;

  exp_t sb[$];

  // ---------------- reference model ----------------
  function automatic int nbytes(input logic [6:0] info);
    if (info[6]) return 8;
    if (info[5]) return 4;
    if (info[4]) return 2;
    return 1;
  endfunction

  function automatic logic [7:0] model_mask(input int n, input int off);
    logic [7:0] m;
    m = 8'h00;
    for (int j = 0; j < 8; j++)
      if (j >= off && j < off + n) m[j] = 1'b1;
    return m;
  endfunction

  function automatic logic [63:0] model_wdata(input logic [63:0] rs2, input int off);
    logic [63:0] r;
    r = 64'd0;
    for (int j = 0; j < 8; j++)
      if (j >= off) r[8*j +: 8] = rs2[8*(j-off) +: 8];
    return r;
  endfunction

  function automatic logic [63:0] model_load(input logic [63:0] rdata, input int off,
                                             input int n, input logic usign);
    logic [63:0] r;
    r = 64'd0;
    for (int i = 0; i < n; i++)
      if (off + i < 8) r[8*i +: 8] = rdata[8*(off+i) +: 8];
    if (!usign && n < 8 && r[8*n-1])
      for (int b = 8*n; b < 64; b++) r[b] = 1'b1;
    return r;
  endfunction

  // ---------------- writeback monitor ----------------
  always @(negedge clk) begin
    if (wb_valid_o) begin
      check("wb_pending", 64'(sb.size() > 0), 64'd1);
      if (sb.size() > 0) begin
        exp_t e;
        e = sb.pop_front();
        check("wb_wr_en",   wb_rd_wr_en_o, e.wr_en);
        check("wb_rd_idx",  wb_rd_idx_o,   e.idx);
        check("wb_data",    wb_data_o,     e.data);
        check("wb_bus_err", bus_err_o,     e.err);
        check("wb_misalign", misalign_o,   e.mis);
        if (e.lat != 0) check("wb_latency", 64'(cyc - e.cyc0), 64'(e.lat));
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic wait_idle();
    int g;
    g = 0;
    @(negedge clk);
    while (!in_ready_o && g < 20) begin
      @(negedge clk);
      g++;
    end
    check("idle_wait", in_ready_o, 1'b1);
  endtask

  task automatic send(input op_t op, input int lat);
    exp_t e;
    logic st, mem, mis;
    int   n, off;
    st  = op.info[1];
    mem = op.info[0] | op.info[1];
    n   = nbytes(op.info);
    off = int'(op.addr[2:0]);
    mis = MIS_EN && mem && ((off % n) != 0);
    e.idx = op.rd;
    e.err = 1'b0;
    e.mis = mis;
    e.lat = lat;
    if (!mem)                begin e.wr_en = op.we; e.data = op.addr; end
    else if (mis)            begin e.wr_en = 1'b0;  e.data = op.addr; end
    else if (op.rdy_dly < 0) begin e.wr_en = 1'b0;  e.data = 64'd0; e.err = 1'b1; end
    else if (st)             begin e.wr_en = 1'b0;  e.data = 64'd0; end
    else begin
      e.wr_en = op.we;
      e.data  = model_load(op.rdata, off, n, op.info[2]);
    end
    if (op.force_exp) e.data = op.exp_data;

    wait_idle();
    e.cyc0 = cyc;
    sb.push_back(e);
    in_valid_i    = 1'b1;
    alu_res_i     = op.addr;
    ls_info_bus_i = op.info;
    rs2_store_i   = op.rs2;
    rd_idx_i      = op.rd;
    rd_wr_en_i    = op.we;
    @(negedge clk);
    in_valid_i    = 1'b0;

    if (mem && !mis) begin
      check("req_valid", mem_req_valid_o, 1'b1);
      check("req_addr",  mem_req_addr_o,  {op.addr[63:3], 3'b000});
      check("req_we",    mem_req_we_o,    st);
      if (st) begin
        check("req_wmask", mem_req_wmask_o, model_mask(n, off));
        check("req_wdata", mem_req_wdata_o, model_wdata(op.rs2, off));
      end
      if (op.rdy_dly < 0) begin
        repeat (TMO - 2) begin
          @(negedge clk);
          check("req_hold", mem_req_valid_o, 1'b1);
        end
        @(negedge clk);
        check("req_drop", mem_req_valid_o, 1'b0);
      end else begin
        repeat (op.rdy_dly) begin
          @(negedge clk);
          check("req_hold", mem_req_valid_o, 1'b1);
          check("req_addr_stable", mem_req_addr_o, {op.addr[63:3], 3'b000});
        end
        mem_req_ready_i = 1'b1;
        @(negedge clk);
        mem_req_ready_i = 1'b0;
        check("rsp_req_low", mem_req_valid_o, 1'b0);
        mem_rsp_valid_i = 1'b1;
        mem_rsp_rdata_i = op.rdata;
        @(negedge clk);
        mem_rsp_valid_i = 1'b0;
      end
    end else if (mem) begin
      check("no_req", mem_req_valid_o, 1'b0);
    end
  endtask

  function automatic op_t mk(input logic [63:0] addr, input logic [6:0] info,
                             input logic [63:0] rs2, input logic [4:0] rd,
                             input logic we, input logic [63:0] rdata, input int dly);
    op_t o;
    o.addr = addr; o.info = info; o.rs2 = rs2; o.rd = rd; o.we = we;
    o.rdata = rdata; o.rdy_dly = dly; o.force_exp = 1'b0; o.exp_data = 64'd0;
    return o;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    op_t o;
    rst = 1'b1;
    in_valid_i = 1'b0; rd_wr_en_i = 1'b0; rd_idx_i = 5'd0;
    alu_res_i = 64'd0; ls_info_bus_i = 7'd0; rs2_store_i = 64'd0;
    mem_req_ready_i = 1'b0; mem_rsp_valid_i = 1'b0; mem_rsp_rdata_i = 64'd0;
    repeat (3) @(negedge clk);
    check("rst_in_ready",  in_ready_o,      1'b1);
    check("rst_req_valid", mem_req_valid_o, 1'b0);
    check("rst_wb_valid",  wb_valid_o,      1'b0);
    check("rst_wb_data",   wb_data_o,       64'd0);
    check("rst_req_addr",  mem_req_addr_o,  64'd0);
    check("rst_wmask",     mem_req_wmask_o, 8'h00);
    check("rst_bus_err",   bus_err_o,       1'b0);
    check("rst_misalign",  misalign_o,      1'b0);
    rst = 1'b0;

    // ALU pass-through: writeback one cycle after accept.
    send(mk(64'h1234, 7'b0000000, 64'd0, 5'd5, 1'b1, 64'd0, 0), 1);
    // Signed byte load, then unsigned.
    o = mk(64'h8000_0003, 7'b0001001, 64'd0, 5'd10, 1'b1, 64'h0000_0000_8000_0000, 0);
    o.force_exp = 1'b1; o.exp_data = 64'hFFFF_FFFF_FFFF_FF80;
    send(o, 3);
    o.info = 7'b0001101; o.exp_data = 64'h0000_0000_0000_0080;
    send(o, 3);
    // Store half at lane 6; writeback must not write the register.
    send(mk(64'h8000_0006, 7'b0010010, 64'hABCD, 5'd7, 1'b1, 64'd0, 0), 3);
    // Back-pressure for one cycle.
    send(mk(64'h8000_0010, 7'b0100001, 64'd0, 5'd3, 1'b1, 64'h1122_3344_F566_7788, 1), 4);
    // Ready held low: bus error four cycles after accept.
    send(mk(64'h8000_0020, 7'b1000001, 64'd0, 5'd9, 1'b1, 64'd0, -1), TMO);
    // Misaligned word load at lane 2.
    o = mk(64'h8000_0002, 7'b0100001, 64'd0, 5'd11, 1'b1, 64'h0000_8765_4321_0000, 0);
    o.force_exp = 1'b1;
    o.exp_data  = MIS_EN ? 64'h0000_0000_8000_0002 : 64'hFFFF_FFFF_8765_4321;
    send(o, MIS_EN ? 1 : 3);
    // Load and store both set: store wins.
    send(mk(64'h8000_0008, 7'b0000011, 64'h55, 5'd12, 1'b1, 64'd0, 0), 3);
    // All size bits set: doubleword, no extension.
    o = mk(64'h8000_0018, 7'b1111001, 64'd0, 5'd13, 1'b1, 64'h8000_0000_0000_0001, 0);
    o.force_exp = 1'b1; o.exp_data = 64'h8000_0000_0000_0001;
    send(o, 3);

    // Random mix against the reference model.
    for (int k = 0; k < 24; k++) begin
      o = mk({$urandom, $urandom}, 7'($urandom), {$urandom, $urandom}, 5'($urandom),
             1'($urandom), {$urandom, $urandom}, int'($urandom_range(0, 1)));
      send(o, 0);
    end

    // Reset while waiting for a response; a late response is ignored.
    wait_idle();
    in_valid_i = 1'b1; alu_res_i = 64'h8000_0040; ls_info_bus_i = 7'b0001001;
    rd_idx_i = 5'd4; rd_wr_en_i = 1'b1;
    @(negedge clk);
    in_valid_i = 1'b0;
    mem_req_ready_i = 1'b1;
    @(negedge clk);
    mem_req_ready_i = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    check("rstrsp_in_ready",  in_ready_o,      1'b1);
    check("rstrsp_req_valid", mem_req_valid_o, 1'b0);
    check("rstrsp_wb_valid",  wb_valid_o,      1'b0);
    rst = 1'b0;
    mem_rsp_valid_i = 1'b1; mem_rsp_rdata_i = 64'hFFFF_FFFF_FFFF_FFFF;
    @(negedge clk);
    mem_rsp_valid_i = 1'b0;
    check("late_rsp_wb_valid", wb_valid_o, 1'b0);
    check("late_rsp_in_ready", in_ready_o, 1'b1);

    // Recovery after reset.
    send(mk(64'hDEAD_BEEF, 7'b0000000, 64'd0, 5'd31, 1'b0, 64'd0, 0), 1);

    repeat (3) @(negedge clk);
    check("sb_empty", 64'(sb.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
